// File: rtl/fpu_sp_result_buf.sv
// Result buffer behind the single-precision add/sub units.
// Captures each result on the producer's rdy strobe, classifies it, and queues
// {flags, data} in a show-ahead FIFO drained through a valid/ready handshake.
// The producer cannot be stalled, so a push into a full buffer with no pop is
// dropped and recorded in a sticky overflow flag.
module fpu_sp_result_buf #(
  parameter int unsigned nBITS = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [nBITS-1:0]         din,
  input  logic                     din_rdy,
  output logic [nBITS-1:0]         dout,
  output logic [4:0]               dout_flags,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = nBITS + 5;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [4:0]        din_flags;
  logic              empty;
  logic              push, pop, drop;
  logic [EntryW-1:0] head;

  // Classify the incoming result; at most one flag set, none for a normal number.
  always_comb begin
    logic [7:0]  exp_f;
    logic [22:0] man_f;
    exp_f     = din[30:23];
    man_f     = din[22:0];
    din_flags = 5'b00000;
    if (exp_f == 8'h00) begin
      if (man_f == 23'd0) din_flags[0] = 1'b1;
      else                din_flags[1] = 1'b1;
    end else if (exp_f == 8'hFF) begin
      if (man_f == 23'd0)  din_flags[2] = 1'b1;
      else if (man_f[22])  din_flags[3] = 1'b1;
      else                 din_flags[4] = 1'b1;
    end
  end

  // Handshake decode and next-state for pointers, occupancy and overflow.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CntW'(DEPTH));
    pop   = !empty && dout_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    push  = din_rdy && (!full || pop);
    drop  = din_rdy && full && !pop;

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new drop beats a clear in the same cycle.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Control state, discarded entirely on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {din_flags, din};
  end

  // Show-ahead head; gated so outputs read zero whenever nothing is held.
  always_comb begin
    head       = mem_q[rptr_q];
    dout_valid = !empty;
    dout       = dout_valid ? head[nBITS-1:0]      : '0;
    dout_flags = dout_valid ? head[EntryW-1:nBITS] : 5'b00000;
    count      = count_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_fpu_sp_result_buf.sv
// Directed bench for fpu_sp_result_buf: reset, classification, overflow,
// full push+pop, streaming and asynchronous reset mid-stream.
module tb_fpu_sp_result_buf;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_rdy;
  logic [31:0] dout;
  logic [4:0]  dout_flags;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  count;
  logic        full;
  logic        ovf;
  logic        ovf_clr;

  int n_cmp;
  int n_bad;

  fpu_sp_result_buf #(
    .nBITS(32),
    .DEPTH(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_rdy   (din_rdy),
    .dout      (dout),
    .dout_flags(dout_flags),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .count     (count),
    .full      (full),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    din     = v;
    din_rdy = 1'b1;
    step();
    din_rdy = 1'b0;
  endtask

  logic [31:0] cls_v [6];
  logic [4:0]  cls_f [6];
  logic [31:0] fill_v [5];
  logic [31:0] pp_v [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cls_v = '{32'h80000000, 32'h00000001, 32'hFF800000, 32'h7FC00000, 32'h7F800001, 32'h3F800000};
    cls_f = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
    fill_v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    pp_v   = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};

    rst = 1'b1; din = '0; din_rdy = 1'b0; dout_ready = 1'b0; ovf_clr = 1'b0;
    step();
    check("rst_valid", dout_valid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dout", dout, 0);
    check("rst_flags", dout_flags, 0);
    rst = 1'b0;
    step();

    // Single push, hold, then accept.
    push(32'h40400000);
    check("s1_valid", dout_valid, 1);
    check("s1_dout", dout, 32'h40400000);
    check("s1_flags", dout_flags, 5'b00000);
    check("s1_count", count, 1);
    step(); step();
    check("s1_hold_dout", dout, 32'h40400000);
    check("s1_hold_valid", dout_valid, 1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("s1_pop_count", count, 0);
    check("s1_pop_valid", dout_valid, 0);

    // Classification sweep, one push per two cycles with consumer ready.
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(cls_v[i]);
      check("cls_dout", dout, cls_v[i]);
      check("cls_flags", dout_flags, cls_f[i]);
      step();
      check("cls_empty", count, 0);
    end
    dout_ready = 1'b0;

    // Fill, overflow, drain, clear.
    for (int i = 0; i < 4; i++) push(fill_v[i]);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_ovf0", ovf, 0);
    push(fill_v[4]);
    check("ovf_set", ovf, 1);
    check("ovf_count", count, 4);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", dout, fill_v[i]);
      step();
    end
    dout_ready = 1'b0;
    check("drain_empty", dout_valid, 0);
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) push(pp_v[i]);
    din = pp_v[4]; din_rdy = 1'b1; dout_ready = 1'b1;
    step();
    din_rdy = 1'b0; dout_ready = 1'b0;
    check("pp_count", count, 4);
    check("pp_ovf", ovf, 0);
    dout_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("pp_drain", dout, pp_v[i]);
      step();
    end
    dout_ready = 1'b0;
    check("pp_empty", count, 0);

    // Back-to-back streaming.
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 32'h42000000 + 32'(i);
      din_rdy = 1'b1;
      step();
      check("str_valid", dout_valid, 1);
      check("str_dout", dout, 32'h42000000 + 32'(i));
      check("str_count", count, 1);
    end
    din_rdy = 1'b0;
    step();
    dout_ready = 1'b0;
    check("str_end", count, 0);

    // Async reset mid-stream with ovf set and three entries held.
    for (int i = 0; i < 5; i++) push(fill_v[i]);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
    check("ar_count3", count, 3);
    check("ar_ovf1", ovf, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", dout_valid, 0);
    check("ar_count", count, 0);
    check("ar_ovf", ovf, 0);
    check("ar_dout", dout, 0);
    step();
    #2 rst = 1'b0;
    step();
    push(32'h40400000);
    check("ar_push_valid", dout_valid, 1);
    check("ar_push_dout", dout, 32'h40400000);
    check("ar_push_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_sp_result_buf.md
Name: fpu_sp_result_buf

Overview:
- Downstream stage of the single-precision add/sub units. Captures each 32-bit IEEE-754 result on the producer's one-cycle `rdy` pulse and classifies it into exception/class flags.
- Buffers result plus flags in a small FIFO and presents them to the consumer (writeback/bus interface) with a valid/ready handshake.
- Decouples the free-running FPU pipeline, which has no backpressure, from a consumer that can stall.

Parameters:
- nBITS, 32, data width (only 32 is supported).
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock, posedge.
- rst  input  1  asynchronous active-high reset.
- din  input  32  result from fpu_sp_add/fpu_sp_sub `result`.
- din_rdy  input  1  producer `rdy`; single-cycle strobe, din valid when high.
- dout  output  32  head-of-FIFO result.
- dout_flags  output  5  class of dout: [0] zero, [1] subnormal, [2] infinity, [3] qNaN, [4] sNaN.
- dout_valid  output  1  dout/dout_flags valid.
- dout_ready  input  1  consumer accepts the head entry when high with dout_valid.
- count  output  $clog2(DEPTH)+1  entries held.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow: a result was dropped.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (async, while rst=1):
  - dout=0, dout_flags=0, dout_valid=0, count=0, full=0, ovf=0.
  - Read/write pointers cleared; stored contents are don't-care.
  - Reset mid-operation discards all entries.
- Storage:
  - DEPTH x 37-bit entries, {flags[4:0], data[31:0]}.
  - Flags are computed combinationally from din at write time and stored with the data.
- Classification, with E=din[30:23] and M=din[22:0]. Exactly one flag is set, or none for a normal number.
  - zero: E==0 and M==0.
  - subnormal: E==0 and M!=0.
  - infinity: E==8'hFF and M==0.
  - qNaN: E==8'hFF and M[22]==1.
  - sNaN: E==8'hFF, M[22]==0 and M!=0.
  - Sign does not affect flags; dout carries the sign unchanged.
- Push:
  - din_rdy=1 and (not full, or pop in the same cycle) -> entry written; wptr increments modulo DEPTH.
- Pop:
  - dout_valid=1 and dout_ready=1 -> head retired; rptr increments modulo DEPTH.
- Output timing:
  - dout/dout_flags/dout_valid are driven from the head entry, i.e. FIFO show-ahead.
  - A push into an empty buffer makes dout_valid=1 in the cycle after the push edge. Latency from din_rdy to dout_valid is 1 cycle.
  - There is no same-cycle bypass.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop or on neither.
- Simultaneous push+pop:
  - When full, the push is accepted, count stays DEPTH, and ovf is not set.
  - When count==1, the new entry becomes the head on the next cycle and dout_valid stays 1.
- Overflow:
  - din_rdy=1 while full and no pop -> din discarded, FIFO contents unchanged, ovf=1 from the next cycle.
  - ovf holds until ovf_clr=1 (cleared at the next edge).
  - If ovf_clr and a new overflow occur in the same cycle, the overflow wins and ovf remains 1.
- Empty: dout_ready with dout_valid=0 is ignored, with no pointer change.
- Handshake stability:
  - While dout_valid=1 and dout_ready=0, dout and dout_flags hold their values.
  - Pushes do not disturb the head entry.
- Pointers: $clog2(DEPTH)-bit, wrapping naturally. full and empty are derived from count.

Test Plan:
- Reset then single push: rst pulse; din=32'h40400000 (3.0), din_rdy one cycle, dout_ready=0 -> next cycle dout_valid=1, dout=32'h40400000, dout_flags=5'b00000, count=1; remains stable until dout_ready=1, then count=0 and dout_valid=0.
- Classification sweep, with dout_ready=1 and one push per 2 cycles:
  - 32'h80000000 -> 5'b00001.
  - 32'h00000001 -> 5'b00010.
  - 32'hFF800000 -> 5'b00100.
  - 32'h7FC00000 -> 5'b01000.
  - 32'h7F800001 -> 5'b10000.
  - 32'h3F800000 -> 5'b00000.
- Fill and overflow:
  - With dout_ready=0, push 1,2,3,4 (as 32'h3F800000..) -> full=1, count=4.
  - Fifth push of 32'h40A00000 -> dropped, ovf=1.
  - Drain -> exactly the first four values, in order.
  - Pulse ovf_clr -> ovf=0.
- Full with simultaneous push+pop:
  - Fill with A,B,C,D, then push E with dout_ready=1 in the same cycle -> count stays 4, ovf=0.
  - Drain order is B,C,D,E.
- Back-to-back streaming: din_rdy every cycle for 16 cycles with dout_ready=1 -> dout_valid stays 1 from cycle 1, every value is delivered in order, and count never exceeds 1.
- Async reset mid-stream: assert rst between clock edges with count=3 -> dout_valid=0, count=0 and ovf=0 immediately; after release, a new push behaves as in scenario 1.
